conv_acc_ctrl: RTL and testbench
================================

// Module: conv_acc_ctrl
// PURPOSE
//  Sequences the 9-tap product adder tree of a conv unit over input channels.
//  Accepts one 3x3 window of products per beat, reduces it in a 2-stage pipelined tree and
//  accumulates NUM_CH beats plus bias into one output pixel, returned over a valid/ready port.
//  Sits between the multiplier array (upstream) and the pooling/writeback stage (downstream).
// PARAMETERS
//  WIDTH     9   operand width; each product is 2*WIDTH signed bits
//  CH_BITS   8   width of channel count; max NUM_CH = 2**CH_BITS-1
//  ACC_W     2*WIDTH+CH_BITS+4   accumulator/output width (signed)
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  start      in   1          pulse: begin a pixel; sampled only in IDLE
//  cfg_num_ch in   CH_BITS    channels to accumulate; latched on start; 0 treated as 1
//  cfg_bias   in   ACC_W      signed bias; latched on start
//  busy       out  1          high from accepted start until output handshake completes
//  in_valid   in   1          product beat valid
//  in_ready   out  1          beat accepted when in_valid&&in_ready
//  in_prod    in   9*2*WIDTH  nine signed products, tap0 at LSBs
//  out_valid  out  1          pixel result valid
//  out_ready  in   1          downstream accepts result
//  out_sum    out  ACC_W      signed accumulated pixel
// BEHAVIOUR
//  - Reset: FSM=IDLE; busy, in_ready, out_valid = 0; out_sum, accumulator, pipe valids, counters = 0.
//  - FSM IDLE->RUN on start; RUN->DRAIN when beat count reaches cfg_num_ch; DRAIN->OUT when pipe empty;
//    OUT->IDLE on out_valid&&out_ready. start outside IDLE ignored.
//  - in_ready = (state==RUN) && beats_accepted < num_ch. No backpressure inside the tree.
//  - Tree: stage1 registers four pair sums + tap8 (sign-extended to 2*WIDTH+1); stage2 registers
//    sum of all nine (2*WIDTH+4 bits). Stage valid bits travel with data. Latency accept->acc = 2 cycles.
//  - Accumulator loaded with bias on start; each stage2-valid adds sign-extended tree sum. No wrap in
//    range: ACC_W sized so 255 channels of max-magnitude products cannot overflow.
//  - OUT: out_sum holds final acc, out_valid held until out_ready; values stable while stalled.
//  - Minimum pixel time: num_ch + 3 cycles (start, beats, 2 drain, out) with back-to-back beats.
//  - Gaps in in_valid allowed; counters advance only on handshake.
//  - rst_n asserted mid-pixel: all state cleared immediately, partial sum discarded, no output.
// CONFIGURATION
//  CONV_RELU_EN defined: out_sum = (acc<0) ? 0 : acc, applied when entering OUT.
//  CONV_RELU_EN undefined: out_sum = acc unmodified (signed, may be negative).
// STRUCTURE
//  Package conv_pkg: state enum {IDLE,RUN,DRAIN,OUT}, TAPS=9 constant, product/acc width functions.
//  Sub-module conv_tree_pipe: 2-stage registered 9-input signed adder with valid pass-through;
//  controller owns FSM, counters, accumulator and handshakes.
// TESTING
//  1 num_ch=1, bias=0, all taps=1 -> out_sum=9, out_valid 4 cycles after start.
//  2 num_ch=3, bias=-5, taps = tap index (0..8) each beat -> out_sum=3*36-5=103.
//  3 num_ch=255, all taps=-(2**(2*WIDTH-1)) -> out_sum=-255*9*131072, exact, no wrap.
//  4 num_ch=4, in_valid toggling every other cycle, out_ready low 5 cycles -> correct sum, out_sum stable
//    while stalled, in_ready low after 4th beat, start during busy ignored.
//  5 num_ch=2, taps sum -20 each, bias 0 -> -40 without CONV_RELU_EN, 0 with it.
//  6 rst_n low after 2 of 5 beats -> busy/out_valid drop at once; next pixel (num_ch=1, taps=1) -> 9.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and width helpers for the conv accumulation controller.
// Build option: CONV_RELU_EN clamps negative pixel results to zero.
package conv_pkg;

   localparam int unsigned TAPS        = 9;
   localparam int unsigned DEF_WIDTH   = 9;
   localparam int unsigned DEF_CH_BITS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

   // signed product width for a given operand width
   function automatic int unsigned prod_w(input int unsigned width);
      return 2 * width;
   endfunction

   // full 9-tap tree sum width
   function automatic int unsigned tree_w(input int unsigned width);
      return 2 * width + 4;
   endfunction

   // accumulator width: headroom for 2**ch_bits-1 channels of tree sums
   function automatic int unsigned acc_w(input int unsigned width, input int unsigned ch_bits);
      return 2 * width + ch_bits + 4;
   endfunction

endpackage

// File: rtl/conv_tree_pipe.sv
// Two-stage registered signed adder tree over nine products with valid pass-through.
module conv_tree_pipe
   import conv_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   input  logic [TAPS*prod_w(WIDTH)-1:0]    in_prod,
   output logic                             s1_valid,
   output logic                             out_valid,
   output logic [tree_w(WIDTH)-1:0]         out_sum
);

   localparam int unsigned PW  = prod_w(WIDTH);
   localparam int unsigned S1W = PW + 1;
   localparam int unsigned SW  = tree_w(WIDTH);
   localparam int unsigned NS1 = 5;

   logic [PW-1:0]  tap_c [TAPS];
   logic [S1W-1:0] s1_c  [NS1];
   logic [S1W-1:0] s1    [NS1];
   logic [SW-1:0]  s2_c;

   // stage1: four pair sums plus sign-extended tap8; stage2: total of the five
   always_comb begin
      for (int i = 0; i < int'(TAPS); i++) begin
         tap_c[i] = in_prod[i*PW +: PW];
      end
      for (int i = 0; i < 4; i++) begin
         s1_c[i] = {tap_c[2*i][PW-1], tap_c[2*i]} + {tap_c[2*i+1][PW-1], tap_c[2*i+1]};
      end
      s1_c[4] = {tap_c[TAPS-1][PW-1], tap_c[TAPS-1]};
      s2_c = '0;
      for (int i = 0; i < int'(NS1); i++) begin
         s2_c = s2_c + {{3{s1[i][S1W-1]}}, s1[i]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         for (int i = 0; i < int'(NS1); i++) begin
            s1[i] <= '0;
         end
      end else begin
         s1_valid  <= in_valid;
         out_valid <= s1_valid;
         if (in_valid) begin
            for (int i = 0; i < int'(NS1); i++) begin
               s1[i] <= s1_c[i];
            end
         end
         if (s1_valid) begin
            out_sum <= s2_c;
         end
      end
   end

endmodule

// File: rtl/conv_acc_ctrl.sv
// Per-pixel controller: sequences product beats through the tree, accumulates channels plus bias.
// Build option: CONV_RELU_EN clamps the final pixel to zero when negative.
module conv_acc_ctrl
   import conv_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned CH_BITS = DEF_CH_BITS,
   parameter int unsigned ACC_W   = acc_w(WIDTH, CH_BITS)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [CH_BITS-1:0]            cfg_num_ch,
   input  logic [ACC_W-1:0]              cfg_bias,
   output logic                          busy,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [TAPS*prod_w(WIDTH)-1:0] in_prod,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ACC_W-1:0]              out_sum
);

   localparam int unsigned SW = tree_w(WIDTH);

   state_t               state, state_n;
   logic [CH_BITS-1:0]   num_ch, num_ch_n;
   logic [CH_BITS-1:0]   count, count_n;
   logic [ACC_W-1:0]     acc, acc_n;
   logic [ACC_W-1:0]     out_sum_n;
   logic                 beat_c;
   logic                 s1_valid;
   logic                 s2_valid;
   logic [SW-1:0]        s2_sum;

   assign beat_c = in_valid && in_ready;

   conv_tree_pipe #(
      .WIDTH (WIDTH)
   ) u_tree (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (beat_c),
      .in_prod   (in_prod),
      .s1_valid  (s1_valid),
      .out_valid (s2_valid),
      .out_sum   (s2_sum)
   );

   // outputs are registered from the next-state values so they track the state exactly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         num_ch    <= '0;
         count     <= '0;
         acc       <= '0;
         out_sum   <= '0;
         busy      <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_n;
         num_ch    <= num_ch_n;
         count     <= count_n;
         acc       <= acc_n;
         out_sum   <= out_sum_n;
         busy      <= (state_n != IDLE);
         in_ready  <= (state_n == RUN);
         out_valid <= (state_n == OUT);
      end
   end

   always_comb begin
      state_n   = state;
      num_ch_n  = num_ch;
      count_n   = count;
      acc_n     = acc;
      out_sum_n = out_sum;

      if (s2_valid) begin
         acc_n = acc + {{(ACC_W-SW){s2_sum[SW-1]}}, s2_sum};
      end

      case (state)
         IDLE: begin
            if (start) begin
               state_n  = RUN;
               num_ch_n = (cfg_num_ch == '0) ? CH_BITS'(1) : cfg_num_ch;
               count_n  = '0;
               acc_n    = cfg_bias;
            end
         end
         RUN: begin
            if (beat_c) begin
               count_n = count + CH_BITS'(1);
               if (count_n == num_ch) begin
                  state_n = DRAIN;
               end
            end
         end
         DRAIN: begin
            // stage1 empty means the last tree sum is folding into acc this cycle
            if (!s1_valid) begin
               state_n = OUT;
`ifdef CONV_RELU_EN
               out_sum_n = acc_n[ACC_W-1] ? '0 : acc_n;
`else
               out_sum_n = acc_n;
`endif
            end
         end
         OUT: begin
            if (out_valid && out_ready) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_conv_acc_ctrl.sv
// Bench for conv_acc_ctrl: table vectors, reset-abort sequence and randomized pixels vs a sum model.
module tb_conv_acc_ctrl;
   import conv_pkg::*;

   localparam int unsigned CH_BITS = 8;
   localparam int unsigned PW      = 18;
   localparam int unsigned ACC_W   = 30;
   localparam int unsigned PRODS   = TAPS * PW;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [CH_BITS-1:0] cfg_num_ch = '0;
   logic [ACC_W-1:0]   cfg_bias = '0;
   logic               busy;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [PRODS-1:0]   in_prod = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [ACC_W-1:0]   out_sum;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   conv_acc_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cfg_num_ch (cfg_num_ch),
      .cfg_bias   (cfg_bias),
      .busy       (busy),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_prod    (in_prod),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sum    (out_sum)
   );

   typedef struct {
      int     nch;
      longint bias;
      int     mode;   // 0 all taps=tapv, 1 tap=index, 2 random, 3 taps sum to -20
      int     tapv;
      int     gap;    // 0 back-to-back, 1 every other cycle, 2 random
      int     stall;
      longint raw;    // hand-derived pre-activation pixel value
   } vec_t;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint relu(input longint x);
`ifdef CONV_RELU_EN
      return (x < 0) ? 0 : x;
`else
      return x;
`endif
   endfunction

   function automatic longint sum_val();
      return longint'($signed(out_sum));
   endfunction

   function automatic logic [PRODS-1:0] make_beat(input int mode, input int tapv, output longint s);
      logic [PRODS-1:0] p;
      int t;
      s = 0;
      for (int i = 0; i < int'(TAPS); i++) begin
         case (mode)
            0:       t = tapv;
            1:       t = i;
            3:       t = (i == 8) ? (-20 - 8 * tapv) : tapv;
            default: t = int'($urandom_range(0, 262143)) - 131072;
         endcase
         p[i*PW +: PW] = PW'(t);
         s += longint'(t);
      end
      return p;
   endfunction

   // drive one pixel from a negedge; returns at a negedge after the output handshake
   task automatic run_pixel(input string name, input int nch, input longint bias, input int mode,
                            input int tapv, input int gap, input int stall,
                            input bit use_raw, input longint raw);
      int eff = (nch == 0) ? 1 : nch;
      longint model = bias;
      longint bsum;
      int sent = 0;
      int cyc = 0;
      bit toggle = 1'b0;
      bit done = 1'b0;
      bit rdy_checked = 1'b0;
      bit offer;
      logic [ACC_W-1:0] held;
      cfg_num_ch = CH_BITS'(nch);
      cfg_bias   = ACC_W'(bias);
      start      = 1'b1;
      out_ready  = 1'b0;
      while (!done && cyc < eff * 4 + 40) begin
         @(negedge clk);
         cyc++;
         start      = 1'b0;
         cfg_num_ch = CH_BITS'($urandom);
         cfg_bias   = ACC_W'($urandom);
         if (cyc == 1) chk({name, "_busy_after_start"}, longint'(busy), 1);
         if (out_valid) begin
            if (gap == 0) chk({name, "_latency"}, longint'(cyc), longint'(eff + 3));
            chk({name, "_sum_model"}, sum_val(), relu(model));
            if (use_raw) chk({name, "_sum_table"}, sum_val(), relu(raw));
            in_valid = 1'b0;
            held = out_sum;
            for (int s = 0; s < stall; s++) begin
               if (s == 1) begin
                  start      = 1'b1;
                  cfg_num_ch = CH_BITS'(7);
               end
               @(negedge clk);
               start = 1'b0;
               chk({name, "_stall_valid"}, longint'(out_valid), 1);
               chk({name, "_stall_stable"}, longint'(out_sum), longint'(held));
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk({name, "_valid_dropped"}, longint'(out_valid), 0);
            chk({name, "_idle_after"}, longint'(busy), 0);
            done = 1'b1;
         end else if (sent < eff) begin
            offer = (gap == 0) || (gap == 1 && toggle) || (gap == 2 && $urandom_range(0, 2) != 0);
            toggle = !toggle;
            in_valid = offer;
            in_prod = make_beat(mode, tapv, bsum);
            if (offer && in_ready) begin
               sent++;
               model += bsum;
            end
         end else begin
            // extra offers after the last beat must not be taken
            in_valid = 1'b1;
            in_prod = make_beat(2, 0, bsum);
            if (!rdy_checked) begin
               chk({name, "_in_ready_low"}, longint'(in_ready), 0);
               rdy_checked = 1'b1;
            end
         end
      end
      in_valid = 1'b0;
      if (!done) chk({name, "_timeout"}, 0, 1);
   endtask

   vec_t tbl[8];

   initial begin
      longint bsum;
      int sent;
      int guard;

      tbl[0] = '{nch: 1,   bias: 0,    mode: 0, tapv: 1,       gap: 0, stall: 0, raw: 9};
      tbl[1] = '{nch: 3,   bias: -5,   mode: 1, tapv: 0,       gap: 0, stall: 0, raw: 103};
      tbl[2] = '{nch: 255, bias: 0,    mode: 0, tapv: -131072, gap: 0, stall: 0, raw: -300810240};
      tbl[3] = '{nch: 4,   bias: 17,   mode: 1, tapv: 0,       gap: 1, stall: 5, raw: 161};
      tbl[4] = '{nch: 2,   bias: 0,    mode: 3, tapv: 5,       gap: 0, stall: 0, raw: -40};
      tbl[5] = '{nch: 0,   bias: 0,    mode: 0, tapv: 2,       gap: 0, stall: 0, raw: 18};
      tbl[6] = '{nch: 2,   bias: -100, mode: 1, tapv: 0,       gap: 0, stall: 0, raw: -28};
      tbl[7] = '{nch: 255, bias: 1000, mode: 0, tapv: 131071,  gap: 0, stall: 2, raw: 300808945};

      repeat (3) @(negedge clk);
      chk("reset_busy", longint'(busy), 0);
      chk("reset_in_ready", longint'(in_ready), 0);
      chk("reset_out_valid", longint'(out_valid), 0);
      chk("reset_out_sum", longint'(out_sum), 0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) begin
         run_pixel($sformatf("vec%0d", i), tbl[i].nch, tbl[i].bias, tbl[i].mode, tbl[i].tapv,
                   tbl[i].gap, tbl[i].stall, 1'b1, tbl[i].raw);
      end

      // abort a 5-channel pixel after two beats
      cfg_num_ch = CH_BITS'(5);
      cfg_bias   = ACC_W'(33);
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sent  = 0;
      guard = 0;
      while (sent < 2 && guard < 20) begin
         in_valid = 1'b1;
         in_prod  = make_beat(0, 1000, bsum);
         if (in_ready) sent++;
         guard++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("abort_beats_taken", longint'(sent), 2);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", longint'(busy), 0);
      chk("abort_out_valid", longint'(out_valid), 0);
      chk("abort_in_ready", longint'(in_ready), 0);
      chk("abort_out_sum", longint'(out_sum), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_pixel("after_abort", 1, 0, 0, 1, 0, 0, 1'b1, 9);

      for (int r = 0; r < 20; r++) begin
         run_pixel($sformatf("rand%0d", r), int'($urandom_range(1, 12)),
                   longint'($urandom_range(0, 2000)) - 1000, 2, 0, 2,
                   int'($urandom_range(0, 3)), 1'b0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
